// File: rtl/dcache_fence_ctrl_pkg.sv
// rtl/dcache_fence_ctrl_pkg.sv - shared types and helpers for the fence controller
package dcache_fence_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_INVAL,
        ST_ICACHE,
        ST_DONE
    } fence_state_e;

    // Bits needed to hold every value 0..max_cnt.
    function automatic int cnt_width(input int unsigned max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/dcache_fence_ctrl_st_cnt.sv
// rtl/dcache_fence_ctrl_st_cnt.sv - saturating outstanding-store counter with sticky error
module fence_st_cnt
    import dcache_fence_ctrl_pkg::*;
#(
    parameter int unsigned MaxCount = 7,
    parameter int          Width    = cnt_width(MaxCount)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic ack,
    output logic empty_next,
    output logic err
);

    localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

    logic [Width-1:0] count;
    logic [Width-1:0] count_next;
    logic             err_set;

    always_comb begin
        count_next = count;
        err_set    = 1'b0;
        if (issue && !ack) begin
            if (count == MaxVal) err_set = 1'b1;
            else                 count_next = count + Width'(1);
        end else if (ack && !issue) begin
            if (count == '0) err_set = 1'b1;
            else             count_next = count - Width'(1);
        end
    end

    // Looking at the next value lets the drain finish in the cycle of the last ack.
    assign empty_next = (count_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            count <= count_next;
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_fence_ctrl.sv
// rtl/dcache_fence_ctrl.sv - sequences store drain, dcache flush/invalidate and icache flush for fences
module dcache_fence_ctrl
    import dcache_fence_ctrl_pkg::*;
#(
    parameter bit          FlushOnFence         = 1'b1,
    parameter bit          InvalidateOnFlush    = 1'b0,
    parameter int unsigned MaxOutstandingStores = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fence_i,
    input  logic fence_i_i,
    input  logic no_st_pending_i,
    input  logic store_issued_i,
    input  logic store_ack_i,
    output logic dcache_flush_o,
    input  logic dcache_flush_ack_i,
    output logic dcache_inval_o,
    input  logic dcache_inval_ack_i,
    output logic icache_flush_o,
    output logic stall_o,
    output logic fence_done_o,
    output logic cnt_err_o
);

    fence_state_e state;
    fence_state_e state_d;
    logic         is_fencei;
    logic         st_empty_next;

    fence_st_cnt #(
        .MaxCount (MaxOutstandingStores)
    ) u_st_cnt (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .issue      (store_issued_i),
        .ack        (store_ack_i),
        .empty_next (st_empty_next),
        .err        (cnt_err_o)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (fence_i || fence_i_i) state_d = ST_DRAIN;
            ST_DRAIN:  if (no_st_pending_i && st_empty_next)
                           state_d = (FlushOnFence || is_fencei) ? ST_FLUSH : ST_DONE;
            ST_FLUSH:  if (dcache_flush_ack_i)
                           state_d = InvalidateOnFlush ? ST_INVAL :
                                     is_fencei         ? ST_ICACHE : ST_DONE;
            ST_INVAL:  if (dcache_inval_ack_i)
                           state_d = is_fencei ? ST_ICACHE : ST_DONE;
            ST_ICACHE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request/pulse outputs are registered decodes of the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            is_fencei      <= 1'b0;
            dcache_flush_o <= 1'b0;
            dcache_inval_o <= 1'b0;
            icache_flush_o <= 1'b0;
            fence_done_o   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && (fence_i || fence_i_i)) is_fencei <= fence_i_i;
            dcache_flush_o <= (state_d == ST_FLUSH);
            dcache_inval_o <= (state_d == ST_INVAL);
            icache_flush_o <= (state_d == ST_ICACHE);
            fence_done_o   <= (state_d == ST_DONE);
        end
    end

    assign stall_o = (state != ST_IDLE) || fence_i || fence_i_i;

endmodule

// File: doc/dcache_fence_ctrl.md
DCACHE_FENCE_CTRL -- requirements
Module: dcache_fence_ctrl

Interface
REQ-001 SHALL have parameter FlushOnFence, default 1, meaning a plain fence flushes the write-back dcache.
REQ-002 SHALL have parameter InvalidateOnFlush, default 0, meaning an invalidate follows every flush.
REQ-003 SHALL have parameter MaxOutstandingStores, default 7, meaning the capacity of the outstanding-store counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port fence_i  input  1  one-cycle pulse: fence committing.
REQ-007 SHALL have port fence_i_i  input  1  one-cycle pulse: fence.i committing.
REQ-008 SHALL have port no_st_pending_i  input  1  store buffer empty.
REQ-009 SHALL have port store_issued_i  input  1  store sent to dcache.
REQ-010 SHALL have port store_ack_i  input  1  dcache acknowledged a store.
REQ-011 SHALL have port dcache_flush_o  output  1  flush request, level, held until ack.
REQ-012 SHALL have port dcache_flush_ack_i  input  1  flush complete pulse.
REQ-013 SHALL have port dcache_inval_o  output  1  invalidate request, level, held until ack.
REQ-014 SHALL have port dcache_inval_ack_i  input  1  invalidate complete pulse.
REQ-015 SHALL have port icache_flush_o  output  1  one-cycle icache flush pulse.
REQ-016 SHALL have port stall_o  output  1  hold commit stage.
REQ-017 SHALL have port fence_done_o  output  1  one-cycle completion pulse.
REQ-018 SHALL have port cnt_err_o  output  1  sticky counter over/underflow flag.

Function
REQ-019 SHALL implement states IDLE, DRAIN, FLUSH, INVAL, ICACHE, DONE.
REQ-020 IDLE: fence_i or fence_i_i -> DRAIN next cycle, latching is_fencei = fence_i_i; both in the same cycle SHALL be treated as fence.i.
REQ-021 DRAIN: when no_st_pending_i=1 and counter=0 -> FLUSH if (FlushOnFence or is_fencei), else DONE; otherwise remain.
REQ-022 FLUSH: dcache_flush_o=1; on dcache_flush_ack_i -> INVAL if InvalidateOnFlush, else ICACHE if is_fencei, else DONE.
REQ-023 INVAL: dcache_inval_o=1; on dcache_inval_ack_i -> ICACHE if is_fencei, else DONE.
REQ-024 ICACHE: icache_flush_o=1 for exactly one cycle -> DONE.
REQ-025 DONE: fence_done_o=1 for exactly one cycle -> IDLE.
REQ-026 dcache_flush_o, dcache_inval_o, icache_flush_o, fence_done_o SHALL be decoded from state only (no input-to-output path).
REQ-027 stall_o SHALL equal (state != IDLE) or fence_i or fence_i_i.
REQ-028 An ack arriving in the first cycle its request is high SHALL be accepted; acks in any other state SHALL be ignored.
REQ-029 fence_i/fence_i_i outside IDLE SHALL be ignored.
REQ-030 Counter width SHALL be clog2(MaxOutstandingStores+1); issue and ack in the same cycle leaves it unchanged.
REQ-031 Issue at MaxOutstandingStores SHALL saturate and set cnt_err_o; ack at 0 SHALL hold 0 and set cnt_err_o.
REQ-032 The counter SHALL track in every state, including IDLE.

Reset
REQ-033 On rst_ni=0: state=IDLE, counter=0, is_fencei=0, cnt_err_o=0, all request/pulse outputs 0; stall_o follows REQ-027.
REQ-034 Reset mid-sequence SHALL abandon the sequence immediately, with no fence_done_o pulse.

Structure
REQ-035 The state enum typedef and the counter-width function SHALL live in the shared core package.
REQ-036 The outstanding-store counter SHALL be a sub-module named fence_st_cnt; the FSM stays in dcache_fence_ctrl.

Verification
REQ-037 Defaults, counter=0, fence at c0, ack at c2 -> DRAIN c1, flush_o c2, done c3, IDLE c4.
REQ-038 FlushOnFence=0, plain fence at c0 -> flush_o never high, done c2.
REQ-039 fence.i with 3 stores outstanding, acked at c4..c6 -> flush_o first high c7, icache_flush_o one cycle after ack.
REQ-040 InvalidateOnFlush=1, fence.i -> order flush_o, inval_o, icache_flush_o, done, each held until its ack.
REQ-041 8 issues, no acks, Max=7 -> counter=7, cnt_err_o=1 sticky; ack at 0 -> counter 0, cnt_err_o=1.
REQ-042 rst_ni low while in FLUSH -> flush_o=0 at once; no done pulse; next fence restarts from DRAIN.
